// File: rtl/im_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// loader state encoding and stream packing constants.
package im_boot_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      DONE
   } state_t;

   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/im_boot_loader_byte_packer.sv
// Collects stream bytes MSB first into a word; word/word_valid are presented
// combinationally on the push that supplies the final byte of a word.
module im_boot_loader_byte_packer
   import im_boot_loader_pkg::*;
#(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [7:0]       byte_data,
   output logic [width-1:0] word,
   output logic             word_valid
);

   logic [1:0]       cnt;
   logic [width-9:0] sr;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
         sr  <= '0;
      end else if (push) begin
         cnt <= cnt + 2'd1;
         sr  <= {sr[width-17:0], byte_data};
      end
   end

   // The final byte bypasses the register so the write can be issued one cycle later.
   assign word       = {sr, byte_data};
   assign word_valid = push && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/im_boot_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes packed words into
// the instruction memory and holds the CPU until a valid image is loaded.
module im_boot_loader
   import im_boot_loader_pkg::*;
#(
   parameter int width     = 32,
   parameter int AddrWidth = 10,
   parameter int num       = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 rx_ready,
   output logic                 we,
   output logic [AddrWidth-1:0] waddr,
   output logic [width-1:0]     wdata,
   output logic [AddrWidth:0]   word_cnt,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 err
);

   localparam int CW = AddrWidth + 1;

   state_t           state, nxt;
   logic             xfer, start_ok, push;
   logic             pk_valid, last_word, hdr_big;
   logic [width-1:0] pk_word;
   logic [7:0]       len_hi;
   logic [CW-1:0]    len;
   logic [15:0]      hdr_n;

   assign xfer      = rx_valid & rx_ready;
   assign hdr_n     = {len_hi, rx_data};
   assign hdr_big   = hdr_n > 16'(num);
   assign last_word = pk_valid && (word_cnt == len - CW'(1));

   im_boot_loader_byte_packer #(.width(width)) u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (start_ok),
      .push       (push),
      .byte_data  (rx_data),
      .word       (pk_word),
      .word_valid (pk_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (start) nxt = LEN_HI;
         LEN_HI:  if (xfer) nxt = LEN_LO;
         LEN_LO:  if (xfer) nxt = (hdr_n == '0 || hdr_big) ? DONE : DATA;
         DATA:    if (last_word) nxt = DONE;
         DONE:    if (start) nxt = LEN_HI;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
      start_ok = start && ((state == IDLE) || (state == DONE));
      push     = xfer && (state == DATA);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_hi   <= '0;
         len      <= '0;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         word_cnt <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         cpu_hold <= 1'b1;
      end else begin
         we <= 1'b0;
         // done/cpu_hold trail DONE entry by one cycle so they follow the final write.
         if (start_ok) begin
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
            cpu_hold <= 1'b1;
         end else if (state == DONE) begin
            done     <= 1'b1;
            cpu_hold <= err;
         end
         if (state == LEN_HI && xfer) len_hi <= rx_data;
         if (state == LEN_LO && xfer) begin
            len <= hdr_n[CW-1:0];
            err <= hdr_big;
         end
         if (pk_valid) begin
            we       <= 1'b1;
            waddr    <= word_cnt[AddrWidth-1:0];
            wdata    <= pk_word;
            word_cnt <= word_cnt + CW'(1);
         end
      end
   end

endmodule
